// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access_pkg: shared encodings for the load/store unit
package lsu_mem_access_pkg;
  localparam logic [1:0] S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2;
  localparam logic [2:0] LD_NONE = 3'b000, ST_NONE = 3'b000;
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_MISAL   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ILLEGAL = 2'b11
  } lsu_err_e;
  // log2 of the load access size; type x00 is the 8-byte load
  function automatic logic [1:0] ld_lsz(input logic [2:0] t);
    return t[1:0] == 2'b00 ? 2'd3 : t[1:0] - 2'd1;
  endfunction
endpackage

// File: rtl/lsu_mem_access_if.sv
// lsu_mem_access_if: aligned 64-bit req/ack memory bus
interface lsu_mem_access_if #(parameter int ADDR_W = 64);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [63:0]       bus_wdata;
  logic [7:0]        bus_wmask;
  logic              bus_ack;
  logic [63:0]       bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, input bus_ack, bus_rdata);
  modport slave  (input bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, output bus_ack, bus_rdata);
endinterface

// File: rtl/lsu_mem_access_load_ext.sv
// lsu_load_ext: aligns a doubleword read to the accessed bytes and sign/zero-extends
module lsu_load_ext (
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [63:0] ext
);
  logic [63:0] s;
  always_comb begin
    s = rdata >> {off, 3'b000};
    ext = size == 2'd0 ? {{56{~uns & s[7]}}, s[7:0]} :
          size == 2'd1 ? {{48{~uns & s[15]}}, s[15:0]} :
          size == 2'd2 ? {{32{~uns & s[31]}}, s[31:0]} : s;
  end
endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: turns one decoded load/store into a single aligned bus transaction
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [2:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic [1:0]        resp_err,
  lsu_mem_access_if.master  bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  logic [1:0]        state_q, state_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [63:0]       bus_wdata_q, bus_wdata_d;
  logic [7:0]        bus_wmask_q, bus_wmask_d;
  logic [2:0]        off_q, off_d;
  logic [1:0]        lsz_q, lsz_d;
  logic              uns_q, uns_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [63:0]       resp_rdata_q, resp_rdata_d;
  lsu_err_e          resp_err_q, resp_err_d;
  logic [1:0]        lsz;
  logic [7:0]        mask;
  logic              illegal, misal, timed_out;
  logic [63:0]       ext;

  lsu_load_ext u_ext (.rdata(bus.bus_rdata), .off(off_q), .size(lsz_q), .uns(uns_q), .ext(ext));

  always_comb begin
    lsz       = mem_read ? ld_lsz(load_type) : store_type[1:0];
    mask      = 8'((9'h1 << (4'd1 << lsz)) - 9'h1);
    illegal   = (mem_read == mem_write) | (mem_read ? load_type == LD_NONE : store_type == ST_NONE);
    misal     = |(addr[2:0] & 3'((4'd1 << lsz) - 4'd1));
    timed_out = (TIMEOUT != 0) && cnt_q == CW'(TIMEOUT - 1);
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wmask_d  = bus_wmask_q;
    off_d        = off_q;
    lsz_d        = lsz_q;
    uns_d        = uns_q;
    cnt_d        = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (state_q == S_IDLE && req_valid) begin
      if (illegal || misal) begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = illegal ? ERR_ILLEGAL : ERR_MISAL;
      end else begin
        state_d     = S_BUS;
        bus_req_d   = 1'b1;
        bus_we_d    = mem_write;
        bus_addr_d  = {addr[ADDR_W-1:3], 3'b000};
        bus_wmask_d = mem_write ? mask << addr[2:0] : 8'hFF;
        bus_wdata_d = mem_write ? wdata << {addr[2:0], 3'b000} : '0;
        off_d       = addr[2:0];
        lsz_d       = lsz;
        uns_d       = load_type[2] & |load_type[1:0];
      end
    end else if (state_q == S_BUS) begin
      if (bus.bus_ack || timed_out) begin
        state_d      = S_RESP;
        bus_req_d    = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = bus.bus_ack ? ERR_OK : ERR_TIMEOUT;
        resp_rdata_d = bus.bus_ack && !bus_we_q ? ext : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wmask_q  <= '0;
      off_q        <= '0;
      lsz_q        <= '0;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wmask_q  <= bus_wmask_d;
      off_q        <= off_d;
      lsz_q        <= lsz_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready     = state_q == S_IDLE;
  assign stall         = state_q != S_IDLE;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wmask = bus_wmask_q;
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: directed vectors for the load/store unit with TIMEOUT=4
module tb_lsu_mem_access;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  load_type = '0, store_type = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic        req_ready, stall, resp_valid;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  int          n_vec = 0, n_bad = 0;

  lsu_mem_access_if #(.ADDR_W(64)) bus ();

  lsu_mem_access #(.TIMEOUT(4), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
    .addr(addr), .wdata(wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [2:0] lt, input logic [2:0] st,
                    input logic [63:0] a, input logic [63:0] wd);
    mem_read = rd; mem_write = wr; load_type = lt; store_type = st; addr = a; wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    #12;
    chk("rst_req", bus.bus_req, 0);
    chk("rst_wmask", bus.bus_wmask, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;
    tick();

    op(0, 1, 3'b000, 3'b100, 64'h1003, 64'hAB);
    chk("sb_req", bus.bus_req, 1);
    chk("sb_we", bus.bus_we, 1);
    chk("sb_addr", bus.bus_addr, 64'h1000);
    chk("sb_mask", bus.bus_wmask, 8'h08);
    chk("sb_wdata", bus.bus_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_stall", stall, 1);
    chk("sb_ready", req_ready, 0);
    tick();
    chk("sb_hold", bus.bus_req, 1);
    bus.bus_ack = 1'b1;
    tick();
    bus.bus_ack = 1'b0;
    chk("sb_rv", resp_valid, 1);
    chk("sb_err", resp_err, 2'b00);
    chk("sb_rdata", resp_rdata, 0);
    chk("sb_reqdrop", bus.bus_req, 0);
    tick();
    chk("sb_rv_end", resp_valid, 0);
    chk("sb_idle", req_ready, 1);

    bus.bus_rdata = 64'h8001_0000_0000_0000;
    bus.bus_ack = 1'b1;
    op(1, 0, 3'b010, 3'b000, 64'h2006, 0);
    chk("lh_req", bus.bus_req, 1);
    chk("lh_we", bus.bus_we, 0);
    chk("lh_mask", bus.bus_wmask, 8'hFF);
    chk("lh_addr", bus.bus_addr, 64'h2000);
    tick();
    chk("lh_rv", resp_valid, 1);
    chk("lh_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
    tick();
    op(1, 0, 3'b110, 3'b000, 64'h2006, 0);
    tick();
    chk("lhu_rv", resp_valid, 1);
    chk("lhu_rdata", resp_rdata, 64'h0000_0000_0000_8001);
    bus.bus_ack = 1'b0;
    tick();

    op(1, 0, 3'b011, 3'b000, 64'h2002, 0);
    chk("lw_rv", resp_valid, 1);
    chk("lw_err", resp_err, 2'b01);
    chk("lw_noreq", bus.bus_req, 0);
    chk("lw_stall", stall, 1);
    tick();
    chk("lw_stall_end", stall, 0);
    chk("lw_rv_end", resp_valid, 0);

    bus.bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    op(1, 0, 3'b100, 3'b000, 64'h2000, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), bus.bus_req, 1);
      chk($sformatf("to_rv%0d", i), resp_valid, 0);
      tick();
    end
    chk("to_reqdrop", bus.bus_req, 0);
    chk("to_rv", resp_valid, 1);
    chk("to_err", resp_err, 2'b10);
    chk("to_rdata", resp_rdata, 0);
    tick();
    chk("to_ready", req_ready, 1);
    chk("to_rv_end", resp_valid, 0);

    op(0, 1, 3'b000, 3'b111, 64'h3008, 64'h55);
    chk("ra_req", bus.bus_req, 1);
    rst_n = 1'b0;
    #1;
    chk("ra_req0", bus.bus_req, 0);
    chk("ra_we0", bus.bus_we, 0);
    chk("ra_addr0", bus.bus_addr, 0);
    chk("ra_wdata0", bus.bus_wdata, 0);
    chk("ra_mask0", bus.bus_wmask, 0);
    chk("ra_stall0", stall, 0);
    bus.bus_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ra_norv%0d", i), resp_valid, 0);
    end
    bus.bus_ack = 1'b0;
    op(0, 1, 3'b000, 3'b111, 64'h3000, 64'h1122_3344_5566_7788);
    chk("sd_mask", bus.bus_wmask, 8'hFF);
    chk("sd_wdata", bus.bus_wdata, 64'h1122_3344_5566_7788);
    chk("sd_addr", bus.bus_addr, 64'h3000);
    bus.bus_ack = 1'b1;
    tick();
    chk("sd_rv", resp_valid, 1);
    tick();

    bus.bus_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    op(0, 1, 3'b000, 3'b111, 64'h4000, 64'h0123_4567_89AB_CDEF);
    mem_read = 1'b1; mem_write = 1'b0; load_type = 3'b100; store_type = 3'b000;
    req_valid = 1'b1;
    tick();
    chk("b2b_sd_rv", resp_valid, 1);
    chk("b2b_sd_rdata", resp_rdata, 0);
    tick();
    chk("b2b_gap1", resp_valid, 0);
    tick();
    req_valid = 1'b0;
    chk("b2b_gap2", resp_valid, 0);
    chk("b2b_ld_req", bus.bus_req, 1);
    tick();
    chk("b2b_ld_rv", resp_valid, 1);
    chk("b2b_ld_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    bus.bus_ack = 1'b0;
    tick();

    op(1, 1, 3'b100, 3'b111, 64'h5000, 0);
    chk("ill_rv", resp_valid, 1);
    chk("ill_err", resp_err, 2'b11);
    chk("ill_noreq", bus.bus_req, 0);
    tick();
    op(0, 1, 3'b000, 3'b000, 64'h5000, 0);
    chk("ill_st_err", resp_err, 2'b11);
    chk("ill_st_noreq", bus.bus_req, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
